// File: rtl/exec_writeback_pkg.sv
// Shared definitions for the execute/writeback stage: opcodes, FSM states
// and opcode classification helpers.
package exec_writeback_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_CLR, OP_ADD, OP_SUB, OP_AND, OP_OR,  OP_SL,  OP_SR, OP_SET,
    OP_INC, OP_DEC, OP_ADC, OP_BZ,  OP_BNZ, OP_JMP, OP_LD, OP_ST
  } op_code;

  typedef enum logic {RUN, MEM_WAIT} wb_state_t;

  function automatic logic is_mem_op(op_code op);
    return op inside {OP_LD, OP_ST};
  endfunction

  function automatic logic writes_rf(op_code op);
    return op inside {OP_CLR, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SL,
                      OP_SR, OP_SET, OP_INC, OP_DEC, OP_ADC};
  endfunction

  function automatic logic updates_carry(op_code op);
    return op inside {OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_ADC};
  endfunction

  function automatic logic is_branch(op_code op);
    return op inside {OP_BZ, OP_BNZ, OP_JMP};
  endfunction

  function automatic logic branch_taken(op_code op, logic z);
    return (op == OP_JMP) || (op == OP_BZ && z) || (op == OP_BNZ && !z);
  endfunction

endpackage

// File: rtl/exec_writeback_if.sv
// Bundle of every signal between the writeback stage and its neighbours
// (upstream ALU, register file, fetch, data memory).
interface exec_writeback_if #(
  parameter int DW  = 8,
  parameter int AW  = 8,
  parameter int RAW = 3
);
  logic           valid_i;
  logic [3:0]     op_i;
  logic [RAW-1:0] rd_i;
  logic [DW-1:0]  result_i;
  logic           ov_i;
  logic           z_i;
  logic [AW-1:0]  addr_i;
  logic [DW-1:0]  st_data_i;
  logic           stall_o;
  logic           carry_o;
  logic           rf_we_o;
  logic [RAW-1:0] rf_waddr_o;
  logic [DW-1:0]  rf_wdata_o;
  logic           br_taken_o;
  logic [AW-1:0]  br_target_o;
  logic           mem_req_o;
  logic           mem_we_o;
  logic [AW-1:0]  mem_addr_o;
  logic [DW-1:0]  mem_wdata_o;
  logic [DW-1:0]  mem_rdata_i;
  logic           mem_ack_i;
  logic           err_o;

  modport slave (
    input  valid_i, op_i, rd_i, result_i, ov_i, z_i, addr_i, st_data_i,
           mem_rdata_i, mem_ack_i,
    output stall_o, carry_o, rf_we_o, rf_waddr_o, rf_wdata_o, br_taken_o,
           br_target_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
  );

  modport master (
    output valid_i, op_i, rd_i, result_i, ov_i, z_i, addr_i, st_data_i,
           mem_rdata_i, mem_ack_i,
    input  stall_o, carry_o, rf_we_o, rf_waddr_o, rf_wdata_o, br_taken_o,
           br_target_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
  );
endinterface

// File: rtl/exec_writeback_mem_timer.sv
// Counts cycles spent waiting on data memory; expired marks the last
// cycle before the access is abandoned.
module mem_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int CW = $clog2(MEM_TIMEOUT);

  logic [CW-1:0] r_count;
  logic          w_expired;

  assign w_expired = (r_count == CW'(MEM_TIMEOUT - 1));
  assign o_expired = w_expired;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst_n)                     r_count <= '0;
    else if (i_clear)               r_count <= '0;
    else if (i_enable && !w_expired) r_count <= r_count + CW'(1);
  end

endmodule

// File: rtl/exec_writeback.sv
// Execute/writeback stage: registers ALU results, owns the carry flag,
// resolves branches and runs LD/ST against data memory with a timeout.
module exec_writeback
  import exec_writeback_pkg::*;
#(
  parameter int DW          = 8,
  parameter int AW          = 8,
  parameter int RAW         = 3,
  parameter int MEM_TIMEOUT = 16
) (
  input logic             clk,
  input logic             rst_n,
  exec_writeback_if.slave bus
);

  wb_state_t      r_state, w_state_next;
  op_code         w_op;
  logic           w_accept, w_ack, w_abort;
  logic           w_stall, w_timer_clear, w_timer_en, w_timer_expired;

  logic           r_carry, r_err;
  logic           r_rf_we, r_br_taken, r_mem_req, r_mem_we;
  logic [RAW-1:0] r_rf_waddr, r_ld_rd;
  logic [DW-1:0]  r_rf_wdata, r_mem_wdata;
  logic [AW-1:0]  r_br_target, r_mem_addr;

  assign w_op     = op_code'(bus.op_i);
  assign w_accept = bus.valid_i && (r_state == RUN);
  // Ack is only meaningful while a request is outstanding; it beats the abort.
  assign w_ack    = (r_state == MEM_WAIT) && bus.mem_ack_i;
  assign w_abort  = (r_state == MEM_WAIT) && !bus.mem_ack_i && w_timer_expired;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_next;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:      if (w_accept && is_mem_op(w_op)) w_state_next = MEM_WAIT;
      MEM_WAIT: if (w_ack || w_abort)            w_state_next = RUN;
      default:                                   w_state_next = RUN;
    endcase
  end

  always_comb begin
    w_stall       = (r_state == MEM_WAIT);
    w_timer_en    = (r_state == MEM_WAIT);
    w_timer_clear = w_accept && is_mem_op(w_op);
  end

  mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_timer_clear),
    .i_enable (w_timer_en),
    .o_expired(w_timer_expired)
  );

  // NOTE: the reset branch clears every register because all of them are
  // plain flops that drive outputs; there is no storage array to exempt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_carry     <= 1'b0;
      r_err       <= 1'b0;
      r_rf_we     <= 1'b0;
      r_rf_waddr  <= '0;
      r_rf_wdata  <= '0;
      r_br_taken  <= 1'b0;
      r_br_target <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_ld_rd     <= '0;
    end else begin
      r_rf_we    <= 1'b0;
      r_br_taken <= 1'b0;

      if (w_accept) begin
        if (writes_rf(w_op)) begin
          r_rf_we    <= 1'b1;
          r_rf_waddr <= bus.rd_i;
          r_rf_wdata <= bus.result_i;
        end
        if (updates_carry(w_op))  r_carry <= bus.ov_i;
        else if (w_op == OP_CLR)  r_carry <= 1'b0;
        if (is_branch(w_op)) begin
          r_br_taken  <= branch_taken(w_op, bus.z_i);
          r_br_target <= bus.addr_i;
        end
        if (is_mem_op(w_op)) begin
          r_mem_req   <= 1'b1;
          r_mem_we    <= (w_op == OP_ST);
          r_mem_addr  <= bus.addr_i;
          r_mem_wdata <= bus.st_data_i;
          r_ld_rd     <= bus.rd_i;
        end
      end

      if (w_ack) begin
        r_mem_req <= 1'b0;
        if (!r_mem_we) begin
          r_rf_we    <= 1'b1;
          r_rf_waddr <= r_ld_rd;
          r_rf_wdata <= bus.mem_rdata_i;
        end
      end

      if (w_abort) begin
        r_mem_req <= 1'b0;
        r_err     <= 1'b1;
      end
    end
  end

  assign bus.stall_o     = w_stall;
  assign bus.carry_o     = r_carry;
  assign bus.rf_we_o     = r_rf_we;
  assign bus.rf_waddr_o  = r_rf_waddr;
  assign bus.rf_wdata_o  = r_rf_wdata;
  assign bus.br_taken_o  = r_br_taken;
  assign bus.br_target_o = r_br_target;
  assign bus.mem_req_o   = r_mem_req;
  assign bus.mem_we_o    = r_mem_we;
  assign bus.mem_addr_o  = r_mem_addr;
  assign bus.mem_wdata_o = r_mem_wdata;
  assign bus.err_o       = r_err;

endmodule
